adder_16_arbiter: RTL and testbench
===================================

# adder_16_arbiter

Round-robin sequencer that time-shares one `adder_16` instance between `NREQ` requesters over valid/ready handshakes. Each accepted beat is added by the shared adder and registered into a single output slot tagged with the requester id. A requester may lock the adder across consecutive beats to perform multi-word (n×16-bit) addition. In that case the carry-out of each beat is fed back as the carry-in of the next. The block sits between arithmetic clients and the `adder_16` datapath and contains the only instance of that adder.

## Interface
- `NREQ`, default 4: number of requesters, legal range 2..8. `IDW = $clog2(NREQ)`.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  bit i: requester i presents a beat.
- `req_ready`  out  NREQ  bit i: beat i accepted this cycle; at most one bit is set.
- `req_in1`  in  16*NREQ  operand A; requester i drives `[16i+15:16i]`.
- `req_in2`  in  16*NREQ  operand B, same packing.
- `req_cin`  in  NREQ  carry-in; used only on the first beat of a chain.
- `req_last`  in  NREQ  1 = final beat of a chain (a single-beat add sets this to 1).
- `rsp_valid`  out  1  output slot holds a result.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  IDW  requester that owns the result.
- `rsp_sum`  out  16  sum.
- `rsp_cout`  out  1  carry-out.
- `rsp_last`  out  1  echo of `req_last` for this beat.

## Operation
- **State:**
  - round-robin pointer `ptr` (IDW bits);
  - `lock` flag plus `owner` (IDW bits);
  - `carry` (1 bit);
  - output slot: `rsp_*` registers.
- **Slot free:** `!rsp_valid || rsp_ready`.
- **Grant, unlocked:** when the slot is free, grant the first i with `req_valid[i]`, scanning from `ptr` upward modulo NREQ.
- **Grant, locked:** only `owner` may be granted, and only when `req_valid[owner]` is high and the slot is free. Other requesters stall even if the adder idles.
- **Ready signal:** `req_ready[i]` is 1 exactly for the granted i. It is combinational from `req_valid`, the state, and `rsp_ready`. Requesters must not make `req_valid` depend on `req_ready`. A raised `req_valid` is held, with operands stable, until accepted.
- **Adder inputs:** `in1`/`in2` come from the granted requester. `cin` is `carry` if `lock` is set, otherwise `req_cin[i]`.
- **On accept:**
  - slot loads sum, cout, `rsp_id` = i, `rsp_last` = `req_last[i]`;
  - `carry` takes cout.
- **Lock transitions:**
  - if `req_last[i]` = 0: `lock` is set and `owner` = i;
  - if `req_last[i]` = 1: `lock` is cleared and `ptr` = (i+1) mod NREQ.
- **Pointer:** `ptr` changes only on accepted last beats.
- **Slot clear:** `rsp_valid` clears on `rsp_valid && rsp_ready` with no new accept. A simultaneous drain and accept reloads the slot, so `rsp_valid` stays 1.
- **Backpressure:** while the slot is full and `rsp_ready` = 0, all `req_ready` = 0 and every `rsp_*` output holds its value.
- **Arithmetic:** plain 16-bit binary addition, `{cout,sum} = in1 + in2 + cin`. No saturation and no sign handling.

## Timing
- **Reset values** (forced asynchronously when `rst_n` = 0):
  - `rsp_valid`, `rsp_sum`, `rsp_cout`, `rsp_id`, `rsp_last` = 0;
  - `ptr`, `lock`, `owner`, `carry` = 0.
- `req_ready` = 0 while `rst_n` = 0.
- **Latency:** a beat accepted at edge t appears on `rsp_*` with `rsp_valid` = 1 immediately after edge t.
- **Throughput:** one beat per cycle with `rsp_ready` held at 1.
- **Reset mid-chain:** lock and carry are discarded. The next beat from the former owner is treated as a chain start and uses its `req_cin`.
- **No requests:** when no `req_valid` is set, state is unchanged except for the slot drain.

## Test plan
- **Single add:** req0 `in1`=0x1234, `in2`=0x0FFF, `cin`=1, `last`=1 -> next cycle `rsp_valid`=1, `rsp_id`=0, `rsp_sum`=0x2234, `rsp_cout`=0.
- **Overflow:** req3 0xFFFF + 0x0001, `cin`=0 -> `rsp_sum`=0x0000, `rsp_cout`=1.
- **Round robin:** all four requesters hold valid single-beat requests, `rsp_ready`=1 -> `rsp_id` sequence 0,1,2,3,0,1 on consecutive cycles.
- **Chain:**
  - stimulus: req2 sends (0xFFFF, 0x0001, `cin`=0, `last`=0) then (0x0000, 0x0000, `cin`=1 ignored, `last`=1), while req1 is valid throughout;
  - required response: id2 sum 0x0000 cout 1; then id2 sum 0x0001 cout 0 `last`=1; then id1.
  - req1 is never granted mid-chain.
- **Backpressure:** slot full, `rsp_ready`=0 for 3 cycles with req0 valid -> `req_ready`=0 and `rsp_*` stable. When `rsp_ready` rises, req0 is accepted the same cycle and its result follows on the next cycle.
- **Reset mid-chain:** assert `rst_n`=0 after req1's first beat (`last`=0) -> all outputs 0. After release, req0 and req1 both valid -> req0 granted first (`ptr`=0, unlocked), and req1's next beat uses `req_cin`.

Source files
------------

// File: rtl/adder_16_arbiter.sv
// adder_16_arbiter: round-robin sharing of a single adder_16 between NREQ
// valid/ready requesters. A requester can lock the adder across beats so
// the carry-out of each beat feeds the carry-in of the next (n x 16-bit add).
// Results land in a one-deep output slot tagged with the requester id.
module adder_16_arbiter #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_in1,
    input  logic [16*NREQ-1:0]   req_in2,
    input  logic [NREQ-1:0]      req_cin,
    input  logic [NREQ-1:0]      req_last,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_sum,
    output logic                 rsp_cout,
    output logic                 rsp_last
);

    localparam int unsigned DW = 16;

    // Open: any requester may win the round-robin scan.
    // Locked: only the chain owner may be granted until its last beat.
    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic            carry_q, carry_d;

    logic            rsp_valid_d;
    logic [IDW-1:0]  rsp_id_d;
    logic [DW-1:0]   rsp_sum_d;
    logic            rsp_cout_d;
    logic            rsp_last_d;

    logic            slot_free;
    logic            gnt_any;
    logic [IDW-1:0]  gnt_id;
    int unsigned     scan_idx;

    logic [DW-1:0]   in1_arr [NREQ];
    logic [DW-1:0]   in2_arr [NREQ];
    logic [DW-1:0]   op_a;
    logic [DW-1:0]   op_b;
    logic            op_cin;
    logic [DW-1:0]   add_sum;
    logic            add_cout;

    // Unpack the flat operand buses into per-requester words.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign in1_arr[g] = req_in1[DW*g +: DW];
        assign in2_arr[g] = req_in2[DW*g +: DW];
    end

    // The slot can take a new beat if it is empty or being drained now.
    assign slot_free = !rsp_valid || rsp_ready;

    // Grant selection: owner only while locked, else first valid from ptr upward.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_id   = '0;
        scan_idx = 0;
        if (rst_n && slot_free) begin
            if (state_q == ST_LOCKED) begin
                if (req_valid[owner_q]) begin
                    gnt_any = 1'b1;
                    gnt_id  = owner_q;
                end
            end else begin
                for (int unsigned k = 0; k < NREQ; k++) begin
                    scan_idx = 32'(ptr_q) + k;
                    if (scan_idx >= NREQ) begin
                        scan_idx = scan_idx - NREQ;
                    end
                    if (!gnt_any && req_valid[IDW'(scan_idx)]) begin
                        gnt_any = 1'b1;
                        gnt_id  = IDW'(scan_idx);
                    end
                end
            end
        end
    end

    // One-hot ready for the granted requester; combinational by design.
    always_comb begin
        req_ready = '0;
        if (gnt_any) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    // Adder operand mux; a locked chain continues from the stored carry.
    always_comb begin
        op_a   = in1_arr[gnt_id];
        op_b   = in2_arr[gnt_id];
        op_cin = (state_q == ST_LOCKED) ? carry_q : req_cin[gnt_id];
    end

    adder_16 u_adder (
        .in1  (op_a),
        .in2  (op_b),
        .cin  (op_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Next-state: lock/pointer/carry updates and output slot load/drain.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        carry_d     = carry_q;
        rsp_valid_d = rsp_valid && !rsp_ready;
        rsp_id_d    = rsp_id;
        rsp_sum_d   = rsp_sum;
        rsp_cout_d  = rsp_cout;
        rsp_last_d  = rsp_last;

        if (gnt_any) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = gnt_id;
            rsp_sum_d   = add_sum;
            rsp_cout_d  = add_cout;
            rsp_last_d  = req_last[gnt_id];
            carry_d     = add_cout;
            if (req_last[gnt_id]) begin
                state_d = ST_OPEN;
                ptr_d   = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
            end else begin
                state_d = ST_LOCKED;
                owner_d = gnt_id;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_OPEN;
            owner_q   <= '0;
            ptr_q     <= '0;
            carry_q   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_last  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            carry_q   <= carry_d;
            rsp_valid <= rsp_valid_d;
            rsp_id    <= rsp_id_d;
            rsp_sum   <= rsp_sum_d;
            rsp_cout  <= rsp_cout_d;
            rsp_last  <= rsp_last_d;
        end
    end

endmodule

// adder_16: plain 16-bit binary adder with carry in/out.
module adder_16 (
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    // Unsigned add, no saturation.
    assign {cout, sum} = 17'(in1) + 17'(in2) + 17'(cin);

endmodule

// File: tb/tb_adder_16_arbiter.sv
// Bench for adder_16_arbiter: directed vectors, multi-cycle corner sequences
// and a randomized run scored against multi-word reference sums.
module tb_adder_16_arbiter;

    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid, req_ready, req_cin, req_last;
    logic [63:0] req_in1, req_in2;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_sum;
    logic        rsp_cout, rsp_last;

    int checks = 0;
    int errors = 0;

    adder_16_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .req_cin   (req_cin),
        .req_last  (req_last),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_last  (rsp_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
    } vec_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] sum;
        logic        cout;
        logic        last;
    } exp_t;

    // Randomized-run requester state: one chain per requester at a time.
    logic [15:0] ra [4][4];
    logic [15:0] rb [4][4];
    logic        rcb[4][4];
    logic [15:0] es [4][4];
    logic        ec [4][4];
    int          rn [4];
    int          rpos[4];
    exp_t        expq[$];
    bit          chain_open;
    logic [1:0]  chain_id;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] rsp_word();
        return 32'({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last});
    endfunction

    function automatic logic [31:0] mk_rsp(input logic v, input logic [1:0] id,
                                           input logic [15:0] s, input logic c, input logic l);
        return 32'({v, id, s, c, l});
    endfunction

    task automatic clear_in();
        req_valid = '0;
        req_cin   = '0;
        req_last  = '0;
        req_in1   = '0;
        req_in2   = '0;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic c, input logic l);
        req_valid[i]        = 1'b1;
        req_in1[16*i +: 16] = a;
        req_in2[16*i +: 16] = b;
        req_cin[i]          = c;
        req_last[i]         = l;
    endtask

    // Leaves the bench just after a rising edge with reset released.
    task automatic do_reset();
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        clear_in();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 3))
            0:       return 16'hFFFF;
            1:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    // New chain for requester i; expected words come from one wide addition.
    task automatic gen_chain(input int i);
        logic [64:0] a_big, b_big, mask, s;
        logic        c0;
        int          n;
        n     = $urandom_range(1, 4);
        c0    = 1'($urandom);
        a_big = '0;
        b_big = '0;
        for (int w = 0; w < n; w++) begin
            ra[i][w]  = pick();
            rb[i][w]  = pick();
            rcb[i][w] = (w == 0) ? c0 : 1'($urandom);
            a_big[16*w +: 16] = ra[i][w];
            b_big[16*w +: 16] = rb[i][w];
        end
        for (int w = 0; w < n; w++) begin
            mask = (65'd1 << (16*(w+1))) - 65'd1;
            s    = (a_big & mask) + (b_big & mask) + 65'(c0);
            es[i][w] = s[16*w +: 16];
            ec[i][w] = s[16*(w+1)];
        end
        rn[i]   = n;
        rpos[i] = 0;
    endtask

    task automatic drive_random(input bit gen_en);
        clear_in();
        for (int i = 0; i < NREQ; i++) begin
            if (gen_en && rpos[i] >= rn[i] && $urandom_range(0, 2) == 0) begin
                gen_chain(i);
            end
            if (rpos[i] < rn[i]) begin
                set_req(i, ra[i][rpos[i]], rb[i][rpos[i]], rcb[i][rpos[i]],
                        (rpos[i] == rn[i] - 1));
            end
        end
    endtask

    // One random cycle: score at the falling edge, then drive after the rise.
    task automatic rnd_cycle(input bit gen_en, input bit force_ready);
        logic [3:0] acc;
        exp_t       e;
        @(negedge clk);
        acc = req_ready;
        chk("rnd_ready_legal", 32'($onehot0(acc) && ((acc & ~req_valid) == 4'd0)), 32'd1);
        if (rsp_valid && rsp_ready) begin
            chk("rnd_rsp_pending", 32'(expq.size() > 0), 32'd1);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("rnd_rsp", 32'({rsp_id, rsp_sum, rsp_cout, rsp_last}), 32'(e));
            end
            if (chain_open) begin
                chk("rnd_chain_contig", 32'(rsp_id), 32'(chain_id));
            end
            chain_open = !rsp_last;
            chain_id   = rsp_id;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                e.id   = 2'(i);
                e.sum  = es[i][rpos[i]];
                e.cout = ec[i][rpos[i]];
                e.last = (rpos[i] == rn[i] - 1);
                expq.push_back(e);
                rpos[i]++;
            end
        end
        @(posedge clk);
        #1;
        rsp_ready = force_ready ? 1'b1 : ($urandom_range(0, 3) != 0);
        drive_random(gen_en);
    endtask

    vec_t tv[6];

    initial begin
        bit done;

        // Reset state: outputs zero, no ready even with all requesters valid.
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        clear_in();
        req_valid = 4'hF;
        #3;
        chk("reset_rsp", rsp_word(), 32'd0);
        chk("reset_ready", 32'(req_ready), 32'd0);
        do_reset();

        // Single-beat vectors.
        tv[0] = '{0, 16'h1234, 16'h0FFF, 1'b1, 16'h2234, 1'b0};
        tv[1] = '{3, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        tv[2] = '{1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tv[3] = '{2, 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1};
        tv[4] = '{0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        tv[5] = '{1, 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0};
        rsp_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            clear_in();
            set_req(tv[v].id, tv[v].a, tv[v].b, tv[v].cin, 1'b1);
            @(negedge clk);
            chk($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(4'd1 << tv[v].id));
            @(posedge clk);
            #1;
            clear_in();
            chk($sformatf("vec%0d_rsp", v), rsp_word(),
                mk_rsp(1'b1, 2'(tv[v].id), tv[v].sum, tv[v].cout, 1'b1));
        end

        // Round robin from ptr=0 with everyone valid.
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 16'(i), 16'h0001, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rr%0d_id", k), 32'({rsp_valid, rsp_id}), 32'({1'b1, 2'(k % 4)}));
        end
        clear_in();

        // Chain on req2 (ptr is now 2) while req1 waits; includes an idle locked cycle.
        @(posedge clk);
        #1;
        chk("chain_drained", 32'(rsp_valid), 32'd0);
        set_req(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        set_req(1, 16'h0001, 16'h0001, 1'b0, 1'b1);
        @(negedge clk);
        chk("chain_b0_ready", 32'(req_ready), 32'h4);
        @(posedge clk);
        #1;
        chk("chain_b0_rsp", rsp_word(), mk_rsp(1'b1, 2'd2, 16'h0000, 1'b1, 1'b0));
        req_valid[2] = 1'b0;
        @(negedge clk);
        chk("chain_lock_stall", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        set_req(2, 16'h0000, 16'h0000, 1'b1, 1'b1);
        @(negedge clk);
        chk("chain_b1_ready", 32'(req_ready), 32'h4);
        @(posedge clk);
        #1;
        chk("chain_b1_rsp", rsp_word(), mk_rsp(1'b1, 2'd2, 16'h0001, 1'b0, 1'b1));
        req_valid[2] = 1'b0;
        @(negedge clk);
        chk("chain_then_req1", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1;
        chk("chain_req1_rsp", rsp_word(), mk_rsp(1'b1, 2'd1, 16'h0002, 1'b0, 1'b1));
        clear_in();

        // Backpressure: slot held for three cycles, then drain and accept together.
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        set_req(0, 16'h0001, 16'h0002, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("bp_fill", rsp_word(), mk_rsp(1'b1, 2'd0, 16'h0003, 1'b0, 1'b1));
        set_req(0, 16'h0005, 16'h0006, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_ready", k), 32'(req_ready), 32'h0);
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_hold", k), rsp_word(), mk_rsp(1'b1, 2'd0, 16'h0003, 1'b0, 1'b1));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("bp_reload", rsp_word(), mk_rsp(1'b1, 2'd0, 16'h000B, 1'b0, 1'b1));
        clear_in();
        @(posedge clk);
        #1;
        chk("bp_drain", 32'(rsp_valid), 32'd0);

        // Reset in the middle of a req1 chain.
        set_req(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_chain_b0", rsp_word(), mk_rsp(1'b1, 2'd1, 16'h0000, 1'b1, 1'b0));
        rst_n = 1'b0;
        set_req(0, 16'h0001, 16'h0001, 1'b0, 1'b1);
        set_req(1, 16'h0000, 16'h0000, 1'b1, 1'b1);
        #1;
        chk("rst_mid_rsp", rsp_word(), 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_after_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("rst_after_req0", rsp_word(), mk_rsp(1'b1, 2'd0, 16'h0002, 1'b0, 1'b1));
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("rst_after_ready1", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1;
        chk("rst_after_req1", rsp_word(), mk_rsp(1'b1, 2'd1, 16'h0001, 1'b0, 1'b1));
        clear_in();

        // Randomized traffic against the wide-add reference.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            rn[i]   = 0;
            rpos[i] = 0;
        end
        expq.delete();
        chain_open = 1'b0;
        chain_id   = '0;
        rsp_ready  = 1'b1;
        drive_random(1'b1);
        for (int c = 0; c < 2000; c++) rnd_cycle(1'b1, 1'b0);
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            rnd_cycle(1'b0, 1'b1);
            done = 1'b1;
            for (int i = 0; i < NREQ; i++) if (rpos[i] < rn[i]) done = 1'b0;
            if (expq.size() != 0 || rsp_valid) done = 1'b0;
        end
        chk("rnd_drain_done", 32'(done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
